// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, flag-class encodings and the
// expected flag class for each function code.
package alu_pkg;

    typedef enum logic [3:0] {
        FUN_ADD  = 4'h0,
        FUN_SUB  = 4'h1,
        FUN_INC  = 4'h2,
        FUN_DEC  = 4'h3,
        FUN_AND  = 4'h4,
        FUN_OR   = 4'h5,
        FUN_XOR  = 4'h6,
        FUN_NOT  = 4'h7,
        FUN_NAND = 4'h8,
        FUN_NOR  = 4'h9,
        FUN_EQ   = 4'hA,
        FUN_CMP  = 4'hB,
        FUN_LT   = 4'hC,
        FUN_SHR  = 4'hD,
        FUN_SHL  = 4'hE,
        FUN_NOP  = 4'hF
    } alu_fun_t;

    // Flag vector ordering is {ARITH, LOGIC, CMP, SHIFT}
    localparam logic [3:0] FLAGS_ARITH = 4'b1000;
    localparam logic [3:0] FLAGS_LOGIC = 4'b0100;
    localparam logic [3:0] FLAGS_CMP   = 4'b0010;
    localparam logic [3:0] FLAGS_SHIFT = 4'b0001;
    localparam logic [3:0] FLAGS_NONE  = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    function automatic logic [3:0] expected_flags(input logic [3:0] fun);
        if (fun <= FUN_DEC)      return FLAGS_ARITH;
        else if (fun <= FUN_NOR) return FLAGS_LOGIC;
        else if (fun <= FUN_LT)  return FLAGS_CMP;
        else if (fun <= FUN_SHL) return FLAGS_SHIFT;
        else                     return FLAGS_NONE;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signals of the ALU command sequencer.
// master = sequencer side, slave = upstream/ALU/downstream environment.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FUN_W = 4
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [WIDTH-1:0] CMD_A;
    logic [WIDTH-1:0] CMD_B;
    logic [FUN_W-1:0] CMD_FUN;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [FUN_W-1:0] ALU_FUN;
    logic [WIDTH-1:0] ALU_OUT;
    logic             ARITH_FLAG;
    logic             LOGIC_FLAG;
    logic             CMP_FLAG;
    logic             SHIFT_FLAG;

    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES_DATA;
    logic [3:0]       RES_FLAGS;
    logic             RES_ERR;
    logic             BUSY;

    modport master (
        input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        input  ALU_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG,
        input  RES_READY,
        output CMD_READY, A, B, ALU_FUN,
        output RES_VALID, RES_DATA, RES_FLAGS, RES_ERR, BUSY
    );

    modport slave (
        output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        output ALU_OUT, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG,
        output RES_READY,
        input  CMD_READY, A, B, ALU_FUN,
        input  RES_VALID, RES_DATA, RES_FLAGS, RES_ERR, BUSY
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead command FIFO with full/empty status.
module alu_cmd_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to a registered ALU, waits
// the ALU latency and returns each result in order with a flag-class check.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FUN_W   = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                RST,
    alu_cmd_sequencer_if.master bus
);
    localparam int unsigned      CMD_W   = 2*WIDTH + FUN_W;
    localparam int unsigned      CNT_W   = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(ALU_LAT);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             accept;
    logic             go_idle;
    logic [CMD_W-1:0] head;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [FUN_W-1:0] fun_q;
    logic [WIDTH-1:0] res_data_q;
    logic [3:0]       res_flags_q;
    logic             res_valid_q;
    logic             res_err_q;
    logic [3:0]       alu_flags;

    assign push      = bus.CMD_VALID & ~fifo_full;
    assign alu_flags = {bus.ARITH_FLAG, bus.LOGIC_FLAG, bus.CMP_FLAG, bus.SHIFT_FLAG};

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RST),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.CMD_A, bus.CMD_B, bus.CMD_FUN}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == LAT_CNT) state_d = ST_HOLD;
            ST_HOLD: if (bus.RES_READY) state_d = fifo_empty ? ST_IDLE : ST_WAIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // HOLD can release a result and pop the next command on the same edge
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        accept  = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            ST_IDLE: pop = ~fifo_empty;
            ST_WAIT: capture = (cnt_q == LAT_CNT);
            ST_HOLD: begin
                accept  = bus.RES_READY;
                pop     = bus.RES_READY & ~fifo_empty;
                go_idle = bus.RES_READY & fifo_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= FUN_W'(FUN_NOP);
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            if (pop) begin
                {a_q, b_q, fun_q} <= head;
            end else if (go_idle) begin
                fun_q <= FUN_W'(FUN_NOP);
            end

            if (pop) begin
                cnt_q <= '0;
            end else if (state_q == ST_WAIT && !capture) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.ALU_OUT;
                res_flags_q <= alu_flags;
                res_err_q   <= (alu_flags != expected_flags(4'(fun_q)));
            end else if (accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.CMD_READY = ~fifo_full;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ALU_FUN   = fun_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_FLAGS = res_flags_q;
    assign bus.RES_ERR   = res_err_q;
    assign bus.BUSY      = ~fifo_empty | (state_q != ST_IDLE);

endmodule
